// File: rtl/apb_i2c_pkg.sv
// Shared types and constants for the APB-to-I2C-core command scheduler.
package apb_i2c_pkg;

   // Transfer sequencing states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // Default bus geometry and wait-state limit
   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_TIMEOUT = 255;

   // Register map of the I2C core on the APB side
   localparam logic [7:0] I2C_PRER_LO = 8'h00;
   localparam logic [7:0] I2C_PRER_HI = 8'h01;
   localparam logic [7:0] I2C_CTR     = 8'h02;
   localparam logic [7:0] I2C_TXR     = 8'h03;
   localparam logic [7:0] I2C_RXR     = 8'h03;
   localparam logic [7:0] I2C_CR      = 8'h04;
   localparam logic [7:0] I2C_SR      = 8'h04;

   // Requester ID to one-hot response strobe
   function automatic logic [1:0] id_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/apb_i2c_scheduler_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   // One-hot grant from the current valids and the last-served pointer
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/apb_i2c_scheduler.sv
// Arbitrates two command requesters onto one APB master port with a
// wait-state timeout; one command outstanding, one response pulse each.
module apb_i2c_scheduler
   import apb_i2c_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [1:0]          req_write,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic [1:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                PSELx,
   output logic                PENABLE,
   output logic                PWRITE,
   output logic [ADDR_W-1:0]   PADDR,
   output logic [DATA_W-1:0]   PWDATA,
   input  logic                PREADY,
   input  logic [DATA_W-1:0]   PRDATA
);

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t     state;
   state_t     state_nx;
   logic [1:0] grant;
   logic [1:0] take;
   logic       last;
   logic       id;
   logic [7:0] cnt;
   logic       accept;
   logic       done_ok;
   logic       done_tmo;

   rr_arb2 u_arb (
      .valid (req_valid),
      .last  (last),
      .grant (grant)
   );

   // State register; reset aborts any transfer in flight
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state, combinational handshake and completion decode
   always_comb begin
      state_nx  = state;
      req_ready = 2'b00;
      take      = grant & req_valid;
      accept    = 1'b0;
      done_ok   = 1'b0;
      done_tmo  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!PRESET) begin
               req_ready = take;
            end else begin
               req_ready = 2'b00;
            end
            if (|req_ready) begin
               accept   = 1'b1;
               state_nx = ST_SETUP;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_nx = ST_ACCESS;
         end
         ST_ACCESS: begin
            // PREADY wins over a simultaneous timeout
            if (PREADY) begin
               done_ok  = 1'b1;
               state_nx = ST_RESP;
            end else if ((cnt + 8'd1) == TMO) begin
               done_tmo = 1'b1;
               state_nx = ST_RESP;
            end else begin
               state_nx = ST_ACCESS;
            end
         end
         ST_RESP: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Command latch, APB drive, timeout count and response registers
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         last      <= 1'b1;
         id        <= 1'b0;
         cnt       <= 8'd0;
         PWRITE    <= 1'b0;
         PADDR     <= {ADDR_W{1'b0}};
         PWDATA    <= {DATA_W{1'b0}};
         PSELx     <= 1'b0;
         PENABLE   <= 1'b0;
         rsp_valid <= 2'b00;
         rsp_rdata <= {DATA_W{1'b0}};
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            id     <= grant[1];
            last   <= grant[1];
            PWRITE <= grant[1] ? req_write[1] : req_write[0];
            PADDR  <= grant[1] ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
            PWDATA <= grant[1] ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
         end
         if (state == ST_ACCESS) begin
            cnt <= cnt + 8'd1;
         end else begin
            cnt <= 8'd0;
         end
         if (done_ok) begin
            rsp_rdata <= PWRITE ? {DATA_W{1'b0}} : PRDATA;
            rsp_err   <= 1'b0;
         end else if (done_tmo) begin
            rsp_rdata <= {DATA_W{1'b0}};
            rsp_err   <= 1'b1;
         end
         PSELx     <= (state_nx == ST_SETUP) || (state_nx == ST_ACCESS);
         PENABLE   <= (state_nx == ST_ACCESS);
         rsp_valid <= (state_nx == ST_RESP) ? id_onehot(id) : 2'b00;
      end
   end

endmodule

// File: tb/tb_apb_i2c_scheduler.sv
// Directed bench for apb_i2c_scheduler (built with TIMEOUT=5).
module tb_apb_i2c_scheduler;
   import apb_i2c_pkg::*;

   logic        PCLK;
   logic        PRESET;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        PSELx;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PADDR;
   logic [7:0]  PWDATA;
   logic        PREADY;
   logic [7:0]  PRDATA;

   int n_assert = 0;
   int n_fail   = 0;

   apb_i2c_scheduler #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(5)) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSELx     (PSELx),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PREADY    (PREADY),
      .PRDATA    (PRDATA)
   );

   // Free-running clock
   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Directed sequence
   initial begin
      logic [1:0] exp_g;
      int         k;

      PRESET    = 1'b1;
      req_valid = 2'b00;
      req_write = 2'b00;
      req_addr  = 16'h0000;
      req_wdata = 16'h0000;
      PREADY    = 1'b0;
      PRDATA    = 8'h00;

      // ---- reset state ----
      @(negedge PCLK);
      req_valid = 2'b01;
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_psel", 32'(PSELx), 32'h0);
      chk("rst_pen", 32'(PENABLE), 32'h0);
      chk("rst_pwrite", 32'(PWRITE), 32'h0);
      chk("rst_paddr", 32'(PADDR), 32'h0);
      chk("rst_pwdata", 32'(PWDATA), 32'h0);
      chk("rst_rspv", 32'(rsp_valid), 32'h0);
      chk("rst_rdata", 32'(rsp_rdata), 32'h0);
      chk("rst_err", 32'(rsp_err), 32'h0);
      req_valid = 2'b00;
      @(negedge PCLK);
      PRESET = 1'b0;

      // ---- single write, PREADY tied high ----
      @(negedge PCLK);
      PREADY    = 1'b1;
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr  = {8'h00, I2C_CTR};
      req_wdata = 16'h00A5;
      #1;
      chk("w_ready", 32'(req_ready), 32'h1);
      @(negedge PCLK);
      req_valid = 2'b00;
      req_addr  = 16'hFFFF;
      req_wdata = 16'hFFFF;
      req_write = 2'b00;
      chk("w_setup_psel", 32'(PSELx), 32'h1);
      chk("w_setup_pen", 32'(PENABLE), 32'h0);
      chk("w_setup_paddr", 32'(PADDR), 32'h02);
      chk("w_setup_pwdata", 32'(PWDATA), 32'hA5);
      chk("w_setup_pwrite", 32'(PWRITE), 32'h1);
      @(negedge PCLK);
      chk("w_acc_psel", 32'(PSELx), 32'h1);
      chk("w_acc_pen", 32'(PENABLE), 32'h1);
      chk("w_acc_paddr", 32'(PADDR), 32'h02);
      chk("w_acc_pwdata", 32'(PWDATA), 32'hA5);
      chk("w_acc_rspv", 32'(rsp_valid), 32'h0);
      @(negedge PCLK);
      chk("w_resp_psel", 32'(PSELx), 32'h0);
      chk("w_resp_rspv", 32'(rsp_valid), 32'h1);
      chk("w_resp_err", 32'(rsp_err), 32'h0);
      chk("w_resp_rdata", 32'(rsp_rdata), 32'h0);
      @(negedge PCLK);
      chk("w_after_rspv", 32'(rsp_valid), 32'h0);

      // ---- read by requester 1 with three wait states ----
      PREADY    = 1'b0;
      PRDATA    = 8'h3C;
      req_valid = 2'b10;
      req_write = 2'b00;
      req_addr  = {I2C_CR, 8'h00};
      #1;
      chk("r_ready", 32'(req_ready), 32'h2);
      @(negedge PCLK);
      req_valid = 2'b00;
      chk("r_setup_psel", 32'(PSELx), 32'h1);
      chk("r_setup_paddr", 32'(PADDR), 32'h04);
      chk("r_setup_pwrite", 32'(PWRITE), 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge PCLK);
         chk("r_acc_pen", 32'(PENABLE), 32'h1);
         chk("r_acc_paddr", 32'(PADDR), 32'h04);
         chk("r_acc_rspv", 32'(rsp_valid), 32'h0);
         if (i == 3) PREADY = 1'b1;
      end
      @(negedge PCLK);
      PREADY = 1'b0;
      chk("r_resp_pen", 32'(PENABLE), 32'h0);
      chk("r_resp_rspv", 32'(rsp_valid), 32'h2);
      chk("r_resp_rdata", 32'(rsp_rdata), 32'h3C);
      chk("r_resp_err", 32'(rsp_err), 32'h0);
      PRDATA = 8'h99;
      @(negedge PCLK);
      chk("r_hold_rspv", 32'(rsp_valid), 32'h0);
      chk("r_hold_rdata", 32'(rsp_rdata), 32'h3C);

      // ---- contention: both valid, four commands each ----
      PREADY    = 1'b1;
      req_valid = 2'b11;
      req_write = 2'b11;
      req_addr  = {8'h20, 8'h10};
      req_wdata = {8'h22, 8'h11};
      for (int i = 0; i < 8; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         chk("rr_ready", 32'(req_ready), 32'(exp_g));
         @(negedge PCLK);
         chk("rr_paddr", 32'(PADDR), (i % 2 == 0) ? 32'h10 : 32'h20);
         @(negedge PCLK);
         @(negedge PCLK);
         chk("rr_rspv", 32'(rsp_valid), 32'(exp_g));
         @(negedge PCLK);
         if (i == 7) req_valid = 2'b00;
      end

      // ---- timeout: PREADY stuck low ----
      PREADY    = 1'b0;
      PRDATA    = 8'h77;
      req_valid = 2'b01;
      req_write = 2'b00;
      req_addr  = {8'h00, I2C_RXR};
      #1;
      chk("to_ready", 32'(req_ready), 32'h1);
      @(negedge PCLK);
      req_valid = 2'b00;
      k = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (PENABLE) k++;
         else break;
      end
      chk("to_acc_cycles", 32'(k), 32'd5);
      chk("to_resp_psel", 32'(PSELx), 32'h0);
      chk("to_resp_rspv", 32'(rsp_valid), 32'h1);
      chk("to_resp_err", 32'(rsp_err), 32'h1);
      chk("to_resp_rdata", 32'(rsp_rdata), 32'h0);
      @(negedge PCLK);
      chk("to_hold_err", 32'(rsp_err), 32'h1);

      // ---- boundary: PREADY on the fifth ACCESS cycle ----
      PRDATA    = 8'h5A;
      req_valid = 2'b10;
      req_addr  = {I2C_SR, 8'h00};
      @(negedge PCLK);
      req_valid = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(negedge PCLK);
         chk("bd_acc_pen", 32'(PENABLE), 32'h1);
         if (i == 4) PREADY = 1'b1;
      end
      @(negedge PCLK);
      PREADY = 1'b0;
      chk("bd_resp_rspv", 32'(rsp_valid), 32'h2);
      chk("bd_resp_err", 32'(rsp_err), 32'h0);
      chk("bd_resp_rdata", 32'(rsp_rdata), 32'h5A);
      @(negedge PCLK);

      // ---- reset during a wait state ----
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr  = {8'h00, I2C_PRER_HI};
      req_wdata = 16'h00C3;
      @(negedge PCLK);
      req_valid = 2'b00;
      @(negedge PCLK);
      chk("mr_acc_pen", 32'(PENABLE), 32'h1);
      #2;
      PRESET = 1'b1;
      #1;
      chk("mr_async_psel", 32'(PSELx), 32'h0);
      chk("mr_async_pen", 32'(PENABLE), 32'h0);
      k = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         if (rsp_valid != 2'b00) k++;
      end
      chk("mr_no_rspv", 32'(k), 32'd0);
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("mr_idle_psel", 32'(PSELx), 32'h0);
      chk("mr_idle_rspv", 32'(rsp_valid), 32'h0);
      // Tie after reset goes to requester 0
      PREADY    = 1'b1;
      req_valid = 2'b11;
      req_write = 2'b11;
      req_addr  = {8'h44, 8'h33};
      #1;
      chk("mr_tie_ready", 32'(req_ready), 32'h1);
      @(negedge PCLK);
      req_valid = 2'b00;
      chk("mr_setup_paddr", 32'(PADDR), 32'h33);
      @(negedge PCLK);
      @(negedge PCLK);
      chk("mr_resp_rspv", 32'(rsp_valid), 32'h1);
      chk("mr_resp_err", 32'(rsp_err), 32'h0);
      @(negedge PCLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_i2c_scheduler.md
APB_I2C_SCHEDULER -- requirements
Module: apb_i2c_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, which sets the APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, which sets the APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, which sets the maximum number of ACCESS cycles before abort (range 1..255).
REQ-004 SHALL have port PCLK, input, width 1: the single clock, rising-edge.
REQ-005 SHALL have port PRESET, input, width 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, width 2: per-requester command valid (bit i = requester i).
REQ-007 SHALL have port req_ready, output, width 2: per-requester command accept.
REQ-008 SHALL have port req_write, input, width 2: per-requester direction (1 = write).
REQ-009 SHALL have port req_addr, input, width 2*ADDR_W: requester i occupies slice [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port req_wdata, input, width 2*DATA_W: requester i occupies slice [i*DATA_W +: DATA_W].
REQ-011 SHALL have port rsp_valid, output, width 2: one-cycle response pulse per requester.
REQ-012 SHALL have port rsp_rdata, output, width DATA_W: read data, shared by both requesters.
REQ-013 SHALL have port rsp_err, output, width 1: timeout flag, qualified by rsp_valid.
REQ-014 SHALL have APB master ports PSELx, PENABLE and PWRITE as outputs of width 1, PADDR as an output of width ADDR_W, and PWDATA as an output of width DATA_W.
REQ-015 SHALL have APB master ports PREADY as an input of width 1 and PRDATA as an input of width DATA_W.

Function
REQ-016 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-017 In IDLE, req_ready[g] SHALL be combinationally 1 only for the granted requester g, and only while req_valid[g]=1; req_ready SHALL be 0 in all other states.
REQ-018 Arbitration SHALL be round-robin: with both requesters valid, the grant goes to the requester that was not served last; a lone valid requester is granted immediately.
REQ-019 On the accept cycle (valid & ready), the block SHALL latch write, addr, wdata and the requester ID, update the last-served pointer, and move to SETUP.
REQ-020 In SETUP, the block SHALL drive PSELx=1, PENABLE=0 and the latched PADDR/PWRITE/PWDATA, then move to ACCESS unconditionally.
REQ-021 In ACCESS, the block SHALL drive PSELx=1 and PENABLE=1 and hold PADDR/PWRITE/PWDATA stable until PREADY=1.
REQ-022 When PREADY=1 is sampled in ACCESS, the block SHALL capture PRDATA (reads only; writes capture 0), clear the error flag, and move to RESP.
REQ-023 The block SHALL count ACCESS cycles with an 8-bit counter; if the count reaches TIMEOUT with PREADY still 0, it SHALL move to RESP with error=1 and rdata=0.
REQ-024 A PREADY=1 in the same cycle that the count reaches TIMEOUT SHALL be treated as success.
REQ-025 In RESP, the block SHALL drive PSELx=0 and PENABLE=0, pulse rsp_valid[id] for exactly one cycle with rsp_rdata/rsp_err valid, then return to IDLE.
REQ-026 Minimum latency SHALL be accept at cycle N, SETUP at N+1, ACCESS at N+2, RESP (rsp_valid) at N+3 when PREADY=1 at N+2.
REQ-027 rsp_valid SHALL have no backpressure; at most one command SHALL be outstanding; at least one idle cycle SHALL separate APB transfers.
REQ-028 Changes on req_* inputs after acceptance SHALL NOT affect the transfer in progress.
REQ-029 rsp_rdata and rsp_err SHALL hold their last values outside RESP.

Reset
REQ-030 While PRESET=1, the block SHALL asynchronously force the state to IDLE and drive PSELx, PENABLE, PWRITE, req_ready, rsp_valid and rsp_err to 0, and PADDR, PWDATA and rsp_rdata to 0.
REQ-031 Reset SHALL clear the timeout counter to 0 and set the last-served pointer to 1, so requester 0 wins the first tie.
REQ-032 An assertion of reset mid-transfer SHALL abort the transfer with no rsp_valid pulse; requesters reissue the command.

Structure
REQ-033 The package apb_i2c_pkg SHALL hold the state enum, default ADDR_W/DATA_W/TIMEOUT, and the I2C core register address constants.
REQ-034 The sub-module rr_arb2 (two-way round-robin grant from valid and last-served pointer) SHALL be the only child; the FSM and datapath SHALL be inline.

Verification
REQ-035 Single write: req0 write addr=0x02 data=0xA5 with PREADY tied to 1 -> PSELx high for 2 cycles, PADDR=0x02, PWDATA=0xA5, rsp_valid[0] at N+3, rsp_err=0.
REQ-036 Read with wait states: req1 read addr=0x04, PREADY low for 3 ACCESS cycles, PRDATA=0x3C -> PENABLE high for 4 cycles, rsp_rdata=0x3C, rsp_valid[1] only.
REQ-037 Contention: both requesters hold valid for 4 commands each -> grants alternate 0,1,0,1,...; no requester is served twice in a row.
REQ-038 Timeout: TIMEOUT=5 with PREADY stuck at 0 -> exactly 5 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSELx low in RESP.
REQ-039 Reset mid-ACCESS: PRESET pulsed during a wait state -> PSELx and PENABLE go to 0 asynchronously, no rsp_valid, and the next command starts cleanly from IDLE.
REQ-040 Boundary: PREADY=1 on the cycle the count reaches TIMEOUT -> rsp_err=0 and PRDATA captured.
